// File: rtl/demux_dispatch_ctrl.sv
// demux_dispatch_ctrl: sequencing controller for the 16-bit 1:4 demultiplexer.
// Accepts words on a valid/ready handshake, routes each one by round-robin or by
// an explicit destination, holds it on the demux until the chosen sink takes it,
// and keeps a per-channel delivered-word counter.
module demux_dispatch_ctrl #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 mode,
    input  logic [1:0]           dest,
    input  logic [3:0]           enable,
    output logic [WIDTH-1:0]     out_data,
    output logic [1:0]           sel,
    output logic [3:0]           out_valid,
    input  logic [3:0]           out_ready,
    output logic                 drop,
    output logic [4*CNT_W-1:0]   count
);

    localparam int unsigned NCH = 4;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t               state_q;
    logic [WIDTH-1:0]     data_q;
    logic [1:0]           sel_q;
    logic [1:0]           ptr_q;
    logic [3:0]           out_valid_q;
    logic                 drop_q;
    logic [4*CNT_W-1:0]   count_q;

    logic                 fire;
    logic                 route_ok;
    logic                 accept;
    logic                 routed;
    logic                 discard;
    logic [1:0]           rr_pick;
    logic [1:0]           next_sel;

    // Round-robin pick: first enabled channel scanning from ptr upwards (mod 4)
    always_comb begin
        logic       found;
        logic [1:0] idx;
        rr_pick = ptr_q;
        found   = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            idx = ptr_q + 2'(k);
            if (!found && enable[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    end

    // Handshake and routing decisions for the current cycle
    always_comb begin
        fire     = (state_q == HOLD) && out_ready[sel_q];
        route_ok = mode ? 1'b1 : (|enable);
        in_ready = ((state_q == IDLE) || fire) && route_ok;
        accept   = in_valid && in_ready;
        routed   = accept && (!mode || enable[dest]);
        discard  = accept && mode && !enable[dest];
        next_sel = mode ? dest : rr_pick;
    end

    // Controller state, held word, pointer, drop pulse and delivery counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            data_q      <= '0;
            sel_q       <= '0;
            ptr_q       <= '0;
            out_valid_q <= '0;
            drop_q      <= 1'b0;
            count_q     <= '0;
        end else begin
            drop_q <= discard;
            if (routed) begin
                state_q     <= HOLD;
                data_q      <= in_data;
                sel_q       <= next_sel;
                out_valid_q <= 4'b0001 << next_sel;
                if (!mode) begin
                    ptr_q <= rr_pick + 2'd1;
                end
            end else if (fire) begin
                state_q     <= IDLE;
                out_valid_q <= '0;
            end
            for (int i = 0; i < NCH; i++) begin
                if (fire && (sel_q == 2'(i))) begin
                    count_q[i*CNT_W +: CNT_W] <= count_q[i*CNT_W +: CNT_W] + CNT_W'(1);
                end
            end
        end
    end

    assign out_data  = data_q;
    assign sel       = sel_q;
    assign out_valid = out_valid_q;
    assign drop      = drop_q;
    assign count     = count_q;

endmodule

// File: doc/demux_dispatch_ctrl.md
# demux_dispatch_ctrl

Sequencing controller for the 16-bit 1:4 demultiplexer. It accepts words over a valid/ready input handshake and selects a destination channel by round-robin or by an explicit destination field. It registers the word and drives the demux data and selector, then holds it until the chosen channel accepts it. It also keeps a per-channel delivered-word counter for debug and bandwidth checks.

## Interface
- WIDTH, 16, data word width (matches demux data width)
- CNT_W, 8, width of each per-channel delivered-word counter
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_data  input  WIDTH  word to dispatch
- in_valid  input  1  in_data valid
- in_ready  output  1  controller can accept in_data this cycle
- mode  input  1  0 = round-robin, 1 = directed (use dest)
- dest  input  2  destination channel in directed mode, sampled with in_data
- enable  input  4  per-channel enable mask; bit i enables channel i
- out_data  output  WIDTH  held word, wired to demux data input
- sel  output  2  held channel index, wired to demux selector
- out_valid  output  4  one-hot; bit i set when the held word targets channel i
- out_ready  input  4  per-channel sink ready
- drop  output  1  one-cycle pulse: directed word to a disabled channel discarded
- count  output  4*CNT_W  delivered-word counters; channel i at bits [i*CNT_W +: CNT_W]

## Operation
- State machine with two states.
  - IDLE: no word held; out_valid = 0.
  - HOLD: word held in data_q/sel_q; out_valid[sel_q] = 1.
- Accept: accept = in_valid & in_ready.
- Fire: fire = HOLD & out_ready[sel_q].
- in_ready = (IDLE | fire) & route_ok.
  - Round-robin mode: route_ok = |enable.
  - Directed mode: route_ok = 1.
- Round-robin pick: the first enabled channel scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - On accept: sel_q ← pick and ptr ← pick+1 (mod 4).
  - ptr changes only on round-robin accepts.
- Directed mode:
  - enable[dest] = 1: on accept, sel_q ← dest; ptr unchanged.
  - enable[dest] = 0: the word is accepted and discarded, drop = 1 next cycle, and the state does not change because of it.
- State transitions:
  - IDLE → HOLD on a routed accept.
  - HOLD → IDLE on fire without a routed accept.
  - HOLD → HOLD on fire with a routed accept (back-to-back, full throughput) or with no fire.
- A held word is committed to its channel. Changes to enable, mode or dest while in HOLD do not re-route it.
- count[sel_q] increments by 1 on fire and wraps modulo 2^CNT_W. Discarded words are not counted.
- out_data = data_q and sel = sel_q at all times. data_q retains its last value in IDLE.

## Timing
- Reset (async assert, sync-released by the surrounding design): state IDLE, ptr = 0, sel = 0, out_data = 0, out_valid = 0, drop = 0, in_ready as the combinational rule gives, all counters = 0.
- Latency: a word accepted at edge N is presented (out_valid, sel, out_data) from edge N to edge N+1. It leaves on the first edge at which its out_ready is high.
- in_ready is combinational from state, out_ready, mode and enable. It has no dependency on in_valid.
- out_valid, sel, out_data and drop are registered outputs.
- Throughput: 1 word/cycle while the target sinks stay ready.
- Stalled channel: the word waits indefinitely and in_ready stays 0. There is no timeout and no head-of-line bypass.
- Round-robin with enable = 0: in_ready = 0 and the controller stalls.
- Reset asserted during HOLD: the held word is lost, and outputs go to reset values immediately (asynchronously).

## Test plan
- Reset, then all 4 channels enabled, round-robin, sinks always ready; send 0x1111, 0x2222, 0x3333, 0x4444, 0x5555 back-to-back.
  - Delivered on channels 0, 1, 2, 3, 0, one per cycle.
  - Each count = 1 except count0 = 2.
- Round-robin, enable = 4'b1010; send 3 words.
  - Delivered on channels 1, 3, 1.
  - Set enable = 0: in_ready = 0.
- Directed mode.
  - dest = 2 with enable[2] = 1, send 0xBEEF: out_valid = 4'b0100, sel = 2, out_data = 0xBEEF.
  - dest = 0 with enable[0] = 0: drop pulses for 1 cycle, no out_valid, counts unchanged.
- Backpressure.
  - Hold out_ready[1] = 0 for 5 cycles with a word targeting channel 1: out_valid[1] and out_data stay stable and in_ready = 0.
  - Release: delivered on that edge, and a pending in_valid word is accepted the same cycle.
- Counter wrap: deliver 256 words to channel 3 with CNT_W = 8; count3 reads 0.
- Asynchronous reset mid-HOLD: drop rst_n between clock edges with a word held; out_valid = 0, sel = 0, counts = 0 with no clock edge.
